char_feeder: RTL and testbench
==============================

// Module: char_feeder
// PURPOSE
//  Upstream stage of the day-1 digit summers. Captures one input file as a byte stream
//  (valid/ready, last-flagged) into an internal buffer, strips carriage returns, then replays
//  it as a gap-free run_o/char_o stream, one char per cycle, in the form the summers consume.
//  Guarantees a priming cycle before the first char and a terminating '\n' on the last line.
// PARAMETERS
//  DEPTH  32768          buffer capacity in bytes; power of two, >= 2
//  AW     $clog2(DEPTH)  buffer address width, derived; do not override
// PORTS
//  clk_i       in   1   clock, single domain
//  rstn_i      in   1   asynchronous reset, active low
//  in_valid_i  in   1   input byte valid
//  in_ready_o  out  1   feeder accepts a byte (handshake = in_valid_i && in_ready_o)
//  in_data_i   in   8   input ASCII byte
//  in_last_i   in   1   qualifies the final byte of the file
//  run_o       out  1   playback active; feeds summer run_i
//  char_o      out  8   playback char; feeds summer char_i
//  done_o      out  1   one-cycle pulse, playback finished
//  overflow_o  out  1   sticky: at least one byte dropped because buffer full
// BEHAVIOUR
//  - Reset (async): state LOAD, in_ready_o=1, run_o=0, char_o=8'h00, done_o=0, overflow_o=0,
//    write count=0. Buffer contents are not cleared and need not be.
//  - States: LOAD -> PRIME -> PLAY -> (TAIL) -> LOAD.
//  - LOAD: in_ready_o=1. On handshake: byte 8'h0D discarded; other bytes written at count,
//    count++. If count==DEPTH, byte dropped, overflow_o<=1, in_ready_o stays 1 (never stall).
//  - Handshake with in_last_i: last byte stored/stripped/dropped as above, then ends the load.
//    Stored count (incl. this byte) >0 -> PRIME. Stored count ==0 -> stay LOAD, done_o pulses
//    next cycle, run_o never rises.
//  - PRIME/PLAY/TAIL: in_ready_o=0; in_valid_i ignored, nothing accepted.
//  - Output timing, all outputs registered. Cycle after the last handshake: run_o=1,
//    char_o=8'h00 (priming; summer leaves IDLE on it). Next count cycles: stored bytes in order,
//    run_o=1. If last stored byte != 8'h0A, one extra cycle char_o=8'h0A (TAIL).
//    Following cycle: run_o=0, char_o=8'h00, done_o=1, state LOAD, count=0, overflow_o cleared.
//  - run_o continuous from prime to final char; no bubbles. Buffer read latency is hidden
//    internally: read issued in PRIME, one cycle ahead.
//  - Total run_o high cycles = 1 + count + (tail ? 1 : 0). Count range 0..DEPTH, width AW+1.
//  - overflow_o holds through playback; clears on done_o cycle. Sample it before or with done_o.
//  - Reset mid-operation: everything returns to reset values immediately. A partial playback
//    is abandoned. The downstream summer is reset from the same rstn_i.
// STRUCTURE
//  - commons package: typedef enum feeder_state_t {LOAD, PRIME, PLAY, TAIL};
//    localparams CHAR_LF=8'h0A, CHAR_CR=8'h0D, CHAR_NUL=8'h00.
//  - Sub-module char_buffer: DEPTH x 8 simple dual-port RAM, 1 write port, 1 synchronous read
//    port (1-cycle latency), no reset on the array.
//  - char_feeder: FSM, write count, read pointer, last-stored-byte register, output registers.
// TESTING
//  1 "1abc2\n" last on '\n' -> run_o high 7 cycles: 00,'1','a','b','c','2',0A;
//    then run_o=0, done_o=1 one cycle.
//  2 "a1\r\nb2" (no final LF) -> 00,'a','1',0A,'b','2',0A; CR absent; done_o after.
//  3 single byte 0D with last -> run_o stays 0, done_o pulses 1 cycle after handshake.
//  4 DEPTH=4, "123456" last on '6' -> overflow_o=1 before playback;
//    plays 00,'1','2','3','4',0A; overflow_o=0 on done_o cycle.
//  5 in_valid_i held high with data 'X' during playback -> in_ready_o=0, no 'X' replayed;
//    next file accepted only after done_o.
//  6 rstn_i low during PLAY of case 1 -> run_o=0, in_ready_o=1 at once;
//    after release, case 1 replays exactly.

Source files
------------

// File: rtl/char_feeder_pkg.sv
// Shared types and character constants for the char_feeder slice.
// Imported by the buffer and the feeder top.
package char_feeder_pkg;

  typedef enum logic [1:0] {
    LOAD,
    PRIME,
    PLAY,
    TAIL
  } feeder_state_t;

  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_NUL = 8'h00;

endpackage

// File: rtl/char_feeder_buffer.sv
// DEPTH x 8 simple dual-port RAM for the char feeder.
// One write port, one synchronous read port with one cycle of latency.
module char_buffer #(
  parameter int DEPTH = 32768,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/char_feeder.sv
// Buffers one CR-stripped file, then replays it as a gap-free
// run_o/char_o stream with a priming NUL and a guaranteed final LF.
module char_feeder
  import char_feeder_pkg::*;
#(
  parameter int DEPTH = 32768,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  input  logic       in_last_i,
  output logic       run_o,
  output logic [7:0] char_o,
  output logic       done_o,
  output logic       overflow_o
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  feeder_state_t state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   rd_q, rd_d;
  logic [7:0]    last_q, last_d;
  logic [7:0]    char_q, char_d;
  logic          run_q, run_d;
  logic          sel_q, sel_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          hs, keep, wr_en, fin;
  logic [7:0]    rd_data;

  assign hs    = in_valid_i && (state_q == LOAD);
  assign keep  = hs && (in_data_i != CHAR_CR);
  assign wr_en = keep && (cnt_q != FULL);

  char_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (in_data_i),
    .raddr_i (rd_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    last_d  = last_q;
    char_d  = char_q;
    run_d   = run_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    fin     = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (wr_en) begin
          cnt_d  = cnt_q + 1'b1;
          last_d = in_data_i;
        end
        if (keep && !wr_en) ovf_d = 1'b1;
        if (hs && in_last_i) begin
          if (cnt_d != '0) begin
            state_d = PRIME;
            run_d   = 1'b1;
            char_d  = CHAR_NUL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      // RAM read for byte 0 goes out here so PLAY starts with data ready
      PRIME: begin
        rd_d    = rd_q + 1'b1;
        sel_d   = 1'b1;
        state_d = PLAY;
      end
      PLAY: begin
        if (rd_q == cnt_q) begin
          sel_d = 1'b0;
          if (last_q != CHAR_LF) begin
            state_d = TAIL;
            char_d  = CHAR_LF;
          end else begin
            fin = 1'b1;
          end
        end else begin
          rd_d = rd_q + 1'b1;
        end
      end
      TAIL: fin = 1'b1;
      default: fin = 1'b1;
    endcase
    if (fin) begin
      state_d = LOAD;
      cnt_d   = '0;
      rd_d    = '0;
      run_d   = 1'b0;
      char_d  = CHAR_NUL;
      sel_d   = 1'b0;
      done_d  = 1'b1;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      rd_q    <= '0;
      last_q  <= CHAR_NUL;
      char_q  <= CHAR_NUL;
      run_q   <= 1'b0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      last_q  <= last_d;
      char_q  <= char_d;
      run_q   <= run_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o = (state_q == LOAD);
  assign run_o      = run_q;
  assign char_o     = sel_q ? rd_data : char_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_char_feeder.sv
// Randomized scoreboard bench for char_feeder.
// Expected streams come from a file-level model of strip/truncate/replay.
module tb_char_feeder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       run;
  logic [7:0] char_v;
  logic       done;
  logic       ovf;

  char_feeder #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .run_o      (run),
    .char_o     (char_v),
    .done_o     (done),
    .overflow_o (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [7:0] ch;
    bit         ovf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fq[$];
  int         errors = 0;
  int         checks = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, req, $time);
    end
  endtask

  task automatic load_str(string s);
    fq.delete();
    for (int i = 0; i < s.len(); i++) fq.push_back(s[i]);
  endtask

  // file-level model: drop CRs, keep first DEPTH bytes, add LF if missing
  task automatic model_push();
    logic [7:0] st[$];
    bit         lost;
    exp_t       e;
    st = {};
    foreach (fq[i]) if (fq[i] != 8'h0D) st.push_back(fq[i]);
    lost = st.size() > DEPTH;
    while (st.size() > DEPTH) void'(st.pop_back());
    if (st.size() > 0) begin
      e = '{0, 8'h00, lost};
      exp_q.push_back(e);
      foreach (st[i]) begin
        e = '{0, st[i], lost};
        exp_q.push_back(e);
      end
      if (st[st.size()-1] != 8'h0A) begin
        e = '{0, 8'h0A, lost};
        exp_q.push_back(e);
      end
    end
    e = '{1, 8'h00, 0};
    exp_q.push_back(e);
  endtask

  task automatic send_file(bit gaps);
    int t;
    for (int i = 0; i < fq.size(); i++) begin
      @(negedge clk);
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = fq[i];
      in_last  = (i == fq.size() - 1);
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) check("ready_timeout", 0, 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("done_timeout", 0, 1);
  endtask

  task automatic run_file(bit gaps);
    model_push();
    send_file(gaps);
    wait_done();
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_run", run, 0);
    check("rst_ready", in_ready, 1);
    check("rst_char", char_v, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn && (run || done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: run=%0b done=%0b char=%0h",
                 run, done, char_v);
      end else begin
        e = exp_q.pop_front();
        check("done_o", done, e.is_done);
        check("run_o", run, !e.is_done);
        check("char_o", char_v, e.ch);
        check("overflow_o", ovf, e.ovf);
        check("in_ready_o", in_ready, e.is_done);
      end
    end
  end

  initial begin
    int   n;
    int   r;
    exp_t e;
    repeat (3) @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);

    load_str("1abc2\n");
    run_file(0);
    load_str("a1\r\nb2");
    run_file(0);
    load_str("\r");
    run_file(0);
    load_str("1234567890");
    run_file(0);

    // input held busy during playback must be ignored
    load_str("7x\n");
    model_push();
    send_file(0);
    in_valid = 1'b1;
    in_data  = "X";
    in_last  = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (n >= 100) check("busy_timeout", 0, 1);
    @(negedge clk);
    load_str("9\n");
    run_file(0);

    // reset in the middle of playback abandons it
    load_str("1abc2\n");
    model_push();
    send_file(0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_reset_vals();
    exp_q.delete();
    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    load_str("1abc2\n");
    run_file(0);

    for (int k = 0; k < 40; k++) begin
      fq.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r < 2) fq.push_back(8'h0D);
        else if (r < 4) fq.push_back(8'h0A);
        else if (r < 7) fq.push_back(8'(48 + $urandom_range(0, 9)));
        else fq.push_back(8'(97 + $urandom_range(0, 25)));
      end
      run_file(1);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
